// File: rtl/hd44780_responder.sv
// hd44780_responder: cycle-level model of an HD44780-style LCD panel acting as
// the responder on an LCD controller bus. Accesses are sampled while e is high
// and committed on the falling edge of e. Instructions update the address
// counter (AC), the mode bits and the busy flag. Data writes emit a write strobe.
//
// Optional feature: define HD44780_DDRAM_EN to add an 80x8 DDRAM. Data writes
// store into it, data reads return DDRAM[AC], and clear display fills it with
// 0x20 while busy. Without the macro there is no RAM and data reads return 0x00.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   e_i, rs_i, rw_i         bus strobe, register select, read/not-write
//   data_in_i               bus write data
//   data_out_o, data_oe_o   bus read data and its drive enable
//   busy_flag_o             instruction in progress
//   addr_ctr_o              address counter AC
//   disp_on_o/cursor_on_o/blink_on_o   display control D/C/B
//   inc_dec_o/shift_en_o    entry mode I/D, S
//   bus8_o/line2_o/font5x10_o          function set DL, N, F
//   wr_strobe_o, wr_addr_o, wr_data_o  one-cycle pulse per accepted data write
//   err_busy_o              sticky: non-status access attempted while busy
module hd44780_responder #(
   parameter int unsigned CLK_FREQ = 360,
   parameter int unsigned EXEC_US  = 37,
   parameter int unsigned CLEAR_US = 1520,
   parameter int unsigned CNT_W    = 20
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       e_i,
   input  logic       rs_i,
   input  logic       rw_i,
   input  logic [7:0] data_in_i,
   output logic [7:0] data_out_o,
   output logic       data_oe_o,
   output logic       busy_flag_o,
   output logic [6:0] addr_ctr_o,
   output logic       disp_on_o,
   output logic       cursor_on_o,
   output logic       blink_on_o,
   output logic       inc_dec_o,
   output logic       shift_en_o,
   output logic       bus8_o,
   output logic       line2_o,
   output logic       font5x10_o,
   output logic       wr_strobe_o,
   output logic [6:0] wr_addr_o,
   output logic [7:0] wr_data_o,
   output logic       err_busy_o
);
   localparam int unsigned AC_W = 7;
   localparam int unsigned DW   = 8;
   localparam logic [CNT_W-1:0] EXEC_CYC  = CNT_W'(EXEC_US * CLK_FREQ);
   localparam logic [CNT_W-1:0] CLEAR_CYC = CNT_W'(CLEAR_US * CLK_FREQ);

   logic            e_q, rs_q, rs_d, rw_q, rw_d;
   logic [DW-1:0]   din_q, din_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic [AC_W-1:0] ac_q, ac_d;
   logic            d_q, d_d, c_q, c_d, b_q, b_d;
   logic            id_q, id_d, s_q, s_d;
   logic            dl_q, dl_d, n_q, n_d, f_q, f_d;
   logic            wstb_q, wstb_d;
   logic [AC_W-1:0] waddr_q, waddr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic            err_q, err_d;
   logic [DW-1:0]   dout_q, dout_d;
   logic            doe_q, doe_d;
   logic [DW-1:0]   rd_byte;
   logic            fall;

   // AC step with the two-line wrap points; decrement is the inverse of increment.
   function automatic logic [AC_W-1:0] ac_step(input logic [AC_W-1:0] ac,
                                               input logic inc, input logic two_line);
      logic [AC_W-1:0] r;
      if (inc) begin
         if (!two_line && ac == 7'h4F)     r = 7'h00;
         else if (two_line && ac == 7'h27) r = 7'h40;
         else if (two_line && ac == 7'h67) r = 7'h00;
         else                              r = ac + 7'd1;
      end else begin
         if (ac == 7'h00)                  r = two_line ? 7'h67 : 7'h4F;
         else if (two_line && ac == 7'h40) r = 7'h27;
         else                              r = ac - 7'd1;
      end
      return r;
   endfunction

   assign fall = e_q & ~e_i;

   // Next-state: bus sampling, commit decode and busy countdown.
   always_comb begin
      rs_d = rs_q;  rw_d = rw_q;  din_d = din_q;
      ac_d = ac_q;
      d_d = d_q;  c_d = c_q;  b_d = b_q;
      id_d = id_q;  s_d = s_q;
      dl_d = dl_q;  n_d = n_q;  f_d = f_q;
      wstb_d = 1'b0;  waddr_d = waddr_q;  wdata_d = wdata_q;
      err_d = err_q;
      cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
      doe_d = e_i & rw_i;
      dout_d = '0;

      if (e_i) begin
         rs_d = rs_i;  rw_d = rw_i;  din_d = data_in_i;
         if (rw_i) dout_d = rs_i ? rd_byte : {busy_q, ac_q};
      end

      if (fall) begin
         if (!rs_q && rw_q) begin
            // status read: no side effects
         end else if (busy_q) begin
            err_d = 1'b1;
         end else if (rs_q) begin
            // data write or data read; both step AC and take the normal busy time
            if (!rw_q) begin
               wstb_d = 1'b1;  waddr_d = ac_q;  wdata_d = din_q;
            end
            ac_d  = ac_step(ac_q, id_q, n_q);
            cnt_d = EXEC_CYC;
         end else begin
            // instruction write, decoded by highest set bit
            cnt_d = EXEC_CYC;
            casez (din_q)
               8'b1???????: ac_d = din_q[6:0];
               8'b01??????: ;
               8'b001?????: begin dl_d = din_q[4]; n_d = din_q[3]; f_d = din_q[2]; end
               8'b0001????: if (!din_q[3]) ac_d = ac_step(ac_q, din_q[2], n_q);
               8'b00001???: begin d_d = din_q[2]; c_d = din_q[1]; b_d = din_q[0]; end
               8'b000001??: begin id_d = din_q[1]; s_d = din_q[0]; end
               8'b0000001?: begin ac_d = '0; cnt_d = CLEAR_CYC; end
               8'b00000001: begin ac_d = '0; id_d = 1'b1; cnt_d = CLEAR_CYC; end
               default:     cnt_d = '0;
            endcase
         end
      end
      busy_d = (cnt_d != '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         e_q <= 1'b0;  rs_q <= 1'b0;  rw_q <= 1'b0;  din_q <= '0;
         cnt_q <= '0;  busy_q <= 1'b0;  ac_q <= '0;
         d_q <= 1'b0;  c_q <= 1'b0;  b_q <= 1'b0;
         id_q <= 1'b1;  s_q <= 1'b0;
         dl_q <= 1'b1;  n_q <= 1'b0;  f_q <= 1'b0;
         wstb_q <= 1'b0;  waddr_q <= '0;  wdata_q <= '0;
         err_q <= 1'b0;  dout_q <= '0;  doe_q <= 1'b0;
      end else begin
         e_q <= e_i;  rs_q <= rs_d;  rw_q <= rw_d;  din_q <= din_d;
         cnt_q <= cnt_d;  busy_q <= busy_d;  ac_q <= ac_d;
         d_q <= d_d;  c_q <= c_d;  b_q <= b_d;
         id_q <= id_d;  s_q <= s_d;
         dl_q <= dl_d;  n_q <= n_d;  f_q <= f_d;
         wstb_q <= wstb_d;  waddr_q <= waddr_d;  wdata_q <= wdata_d;
         err_q <= err_d;  dout_q <= dout_d;  doe_q <= doe_d;
      end
   end

`ifdef HD44780_DDRAM_EN
   localparam int unsigned RAM_N = 80;
   localparam int unsigned IDX_W = 7;

   logic [DW-1:0]    ram_q [RAM_N];
   logic             clr_act_q, clr_act_d, clr_start;
   logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
   logic             ram_we;
   logic [IDX_W-1:0] ram_idx;
   logic [DW-1:0]    ram_wdata;
   logic [IDX_W:0]   rd_slot, wr_slot;

   // Map AC to a RAM slot: {valid, index}; line 2 (0x40..0x67) follows line 1.
   function automatic logic [IDX_W:0] slot(input logic [AC_W-1:0] ac, input logic two_line);
      logic [IDX_W:0] r;
      r = '0;
      if (!two_line) begin
         if (ac < 7'd80) r = {1'b1, ac};
      end else if (ac < 7'h28) begin
         r = {1'b1, ac};
      end else if (ac >= 7'h40 && ac < 7'h68) begin
         r = {1'b1, 7'(ac - 7'd24)};
      end
      return r;
   endfunction

   assign clr_start = fall & ~busy_q & ~rs_q & ~rw_q & (din_q == 8'h01);
   assign rd_slot   = slot(ac_q, n_q);
   assign rd_byte   = rd_slot[IDX_W] ? ram_q[rd_slot[IDX_W-1:0]] : '0;

   // RAM write port: clear sweep (one byte per cycle) or an accepted data write.
   always_comb begin
      clr_act_d = clr_act_q;
      clr_idx_d = clr_idx_q;
      ram_we    = 1'b0;
      ram_idx   = clr_idx_q;
      ram_wdata = 8'h20;
      wr_slot   = slot(ac_q, n_q);
      if (clr_act_q) begin
         ram_we = 1'b1;
         if (clr_idx_q == IDX_W'(RAM_N - 1)) clr_act_d = 1'b0;
         else                                 clr_idx_d = clr_idx_q + IDX_W'(1);
      end else if (wstb_d && wr_slot[IDX_W]) begin
         ram_we    = 1'b1;
         ram_idx   = wr_slot[IDX_W-1:0];
         ram_wdata = din_q;
      end
      if (clr_start) begin
         clr_act_d = 1'b1;
         clr_idx_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clr_act_q <= 1'b0;
         clr_idx_q <= '0;
      end else begin
         clr_act_q <= clr_act_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (ram_we) ram_q[ram_idx] <= ram_wdata;
   end
`else
   assign rd_byte = '0;
`endif

   assign data_out_o  = dout_q;
   assign data_oe_o   = doe_q;
   assign busy_flag_o = busy_q;
   assign addr_ctr_o  = ac_q;
   assign disp_on_o   = d_q;
   assign cursor_on_o = c_q;
   assign blink_on_o  = b_q;
   assign inc_dec_o   = id_q;
   assign shift_en_o  = s_q;
   assign bus8_o      = dl_q;
   assign line2_o     = n_q;
   assign font5x10_o  = f_q;
   assign wr_strobe_o = wstb_q;
   assign wr_addr_o   = waddr_q;
   assign wr_data_o   = wdata_q;
   assign err_busy_o  = err_q;
endmodule

// File: tb/tb_hd44780_responder.sv
// Bench for hd44780_responder with a reduced clock rate (2 clk per us) so the
// busy windows are 74 (normal) and 3040 (clear/home) cycles.
module tb_hd44780_responder;
   localparam int unsigned CLK_FREQ = 2;
   localparam int unsigned EXEC_US  = 37;
   localparam int unsigned CLEAR_US = 1520;
   localparam int unsigned CNT_W    = 20;
   localparam int EXEC_CYC  = 74;
   localparam int CLEAR_CYC = 3040;
`ifdef HD44780_DDRAM_EN
   localparam logic [7:0] RD_BLANK = 8'h20;
   localparam logic [7:0] RD_WRITTEN = 8'h48;
`else
   localparam logic [7:0] RD_BLANK = 8'h00;
   localparam logic [7:0] RD_WRITTEN = 8'h00;
`endif

   logic       clk = 1'b0, rst = 1'b1, e = 1'b0, rs = 1'b0, rw = 1'b0;
   logic [7:0] din = '0;
   logic [7:0] dout, wdata;
   logic [6:0] ac, waddr;
   logic       doe, busy, disp, cur, blink, incd, shft, b8, l2, f510, wstb, err;

   int total = 0;
   int bad   = 0;

   logic [14:0] wq[$];
   logic [7:0]  rq[$];
   int          bq[$];

   hd44780_responder #(.CLK_FREQ(CLK_FREQ), .EXEC_US(EXEC_US),
                       .CLEAR_US(CLEAR_US), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst), .e_i(e), .rs_i(rs), .rw_i(rw), .data_in_i(din),
      .data_out_o(dout), .data_oe_o(doe), .busy_flag_o(busy), .addr_ctr_o(ac),
      .disp_on_o(disp), .cursor_on_o(cur), .blink_on_o(blink),
      .inc_dec_o(incd), .shift_en_o(shft),
      .bus8_o(b8), .line2_o(l2), .font5x10_o(f510),
      .wr_strobe_o(wstb), .wr_addr_o(waddr), .wr_data_o(wdata), .err_busy_o(err));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: pops expected writes, read data and busy lengths as the DUT presents them.
   logic [7:0]  last_rd;
   logic        oe_seen = 1'b0;
   int          busy_run = 0;
   logic [14:0] wexp;
   logic [7:0]  rexp;
   int          bexp;
   always @(negedge clk) begin
      if (!rst) begin
         if (wstb === 1'b1) begin
            if (wq.size() == 0) begin
               total++; bad++;
               $display("FAIL wr_unexpected actual=%0h expected=none", {waddr, wdata});
            end else begin
               wexp = wq.pop_front();
               chk("wr_addr_data", {17'd0, waddr, wdata}, {17'd0, wexp});
            end
         end
         if (doe === 1'b1) begin
            last_rd = dout;
            oe_seen = 1'b1;
         end else if (oe_seen) begin
            oe_seen = 1'b0;
            if (rq.size() == 0) begin
               total++; bad++;
               $display("FAIL rd_unexpected actual=%0h expected=none", last_rd);
            end else begin
               rexp = rq.pop_front();
               chk("rd_data", {24'd0, last_rd}, {24'd0, rexp});
            end
         end
         if (busy === 1'b1) begin
            busy_run++;
         end else if (busy_run > 0) begin
            if (bq.size() == 0) begin
               total++; bad++;
               $display("FAIL busy_unexpected actual=%0d expected=none", busy_run);
            end else begin
               bexp = bq.pop_front();
               chk("busy_len", busy_run, bexp);
            end
            busy_run = 0;
         end
      end
   end

   // One bus access: e high for 'hold' cycles, then low; returns two cycles after commit.
   task automatic access(input logic r_s, input logic r_w, input logic [7:0] d, input int hold);
      @(posedge clk); #1;
      e = 1'b1; rs = r_s; rw = r_w; din = d;
      repeat (hold) @(posedge clk);
      #1 e = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 10000) begin
         @(posedge clk); #1; n++;
      end
      chk("idle_reached", {31'd0, busy}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic [7:0] d, input int blen);
      if (blen > 0) bq.push_back(blen);
      access(1'b0, 1'b0, d, 10);
      wait_idle();
   endtask

   task automatic dwrite(input logic [6:0] at, input logic [7:0] d);
      wq.push_back({at, d});
      bq.push_back(EXEC_CYC);
      access(1'b1, 1'b0, d, 10);
   endtask

   task automatic dread(input logic [7:0] exp);
      rq.push_back(exp);
      bq.push_back(EXEC_CYC);
      access(1'b1, 1'b1, 8'h00, 10);
   endtask

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk); #1 rst = 1'b0;
      chk("rst_ac", ac, 0);      chk("rst_busy", busy, 0);
      chk("rst_id", incd, 1);    chk("rst_dl", b8, 1);
      chk("rst_n", l2, 0);       chk("rst_d", disp, 0);
      chk("rst_err", err, 0);    chk("rst_oe", doe, 0);
      chk("rst_dout", dout, 0);

      instr(8'h38, EXEC_CYC);
      chk("fs_dl", b8, 1); chk("fs_n", l2, 1); chk("fs_f", f510, 0);
      instr(8'h0F, EXEC_CYC);
      chk("dc_dcb", {disp, cur, blink}, 3'b111);
      instr(8'h06, EXEC_CYC);
      chk("em_ids", {incd, shft}, 2'b10);
      access(1'b0, 1'b0, 8'h00, 10);
      chk("nop_busy", busy, 0);

      // clear display with a status read inside the busy window
      bq.push_back(CLEAR_CYC);
      access(1'b0, 1'b0, 8'h01, 10);
      rq.push_back(8'h80);
      access(1'b0, 1'b1, 8'h00, 3);
      chk("clr_err", err, 0);
      wait_idle();
      chk("clr_ac", ac, 0);

      // line-1 end wraps to line 2 on a data write
      instr(8'hA7, EXEC_CYC);
      dwrite(7'h27, 8'h41);
      chk("wrap_ac", ac, 7'h40);
      wait_idle();

      // second write while busy is ignored and flagged
      dwrite(7'h40, 8'h43);
      access(1'b1, 1'b0, 8'h44, 3);
      chk("busy_wr_ac", ac, 7'h41);
      chk("busy_wr_err", err, 1);
      wait_idle();
      chk("busy_wr_ac2", ac, 7'h41);

      // decrement across the line boundary and from 0x00
      instr(8'h04, EXEC_CYC);
      chk("dec_id", incd, 0);
      instr(8'hC0, EXEC_CYC);
      dwrite(7'h40, 8'h55);
      chk("dec_ac", ac, 7'h27);
      wait_idle();
      instr(8'h80, EXEC_CYC);
      dread(RD_BLANK);
      chk("dec0_ac", ac, 7'h67);
      wait_idle();

      // cursor shift instructions
      instr(8'h10, EXEC_CYC); chk("shl_ac", ac, 7'h66);
      instr(8'h14, EXEC_CYC); chk("shr_ac", ac, 7'h67);
      instr(8'h14, EXEC_CYC); chk("shr_wrap", ac, 7'h00);
      instr(8'h18, EXEC_CYC); chk("dshift_ac", ac, 7'h00);

      // single-line mode wrap at 0x4F
      instr(8'h20, EXEC_CYC);
      chk("fs1_n", l2, 0); chk("fs1_dl", b8, 0);
      instr(8'h06, EXEC_CYC);
      instr(8'hCF, EXEC_CYC);
      dwrite(7'h4F, 8'h61);
      chk("n0_wrap", ac, 7'h00);
      wait_idle();

      // write/read back, return home, then clear and read again
      instr(8'h85, EXEC_CYC);
      dwrite(7'h05, 8'h48);
      wait_idle();
      chk("wr5_ac", ac, 7'h06);
      instr(8'h85, EXEC_CYC);
      dread(RD_WRITTEN);
      wait_idle();
      chk("rd5_ac", ac, 7'h06);
      instr(8'h02, CLEAR_CYC);
      chk("home_ac", ac, 7'h00);
      instr(8'h01, CLEAR_CYC);
      instr(8'h85, EXEC_CYC);
      dread(RD_BLANK);
      wait_idle();

      rq.push_back(8'h06);
      access(1'b0, 1'b1, 8'h00, 3);
      chk("err_sticky", err, 1);

      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("rst2_err", err, 0); chk("rst2_ac", ac, 0);
      chk("rst2_dl", b8, 1);   chk("rst2_n", l2, 0);
      chk("rst2_d", disp, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("wq_left", wq.size(), 0);
      chk("rq_left", rq.size(), 0);
      chk("bq_left", bq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
